fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch sequencer that consumes the program counter value and drives it to instruction memory through a req/ack handshake. It returns the fetched word to decode over a valid/ready interface. It also drives the PC halt input, so the PC advances only after an instruction is accepted or flushed. It includes a watchdog that traps a hung memory.

Parameters:
ADDR_W, 32, width of pc and imem_addr
DATA_W, 32, width of instruction word
TIMEOUT, 16, max cycles in REQ without imem_ack before error (>=2)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous active-low reset (reset==0 at posedge clears block)
pc  input  ADDR_W  current PC value, stable at posedge
pc_halt  output  1  to PC halt input; 1 = hold PC
imem_req  output  1  memory request, held until ack
imem_addr  output  ADDR_W  registered fetch address
imem_ack  input  1  one-cycle ack; imem_rdata valid same cycle
imem_rdata  input  DATA_W  fetched word
instr  output  DATA_W  instruction to decode
instr_valid  output  1  instr is valid
instr_ready  input  1  decode accepts instr
flush  input  1  one-cycle pulse: discard in-flight or held instruction
fetch_err  output  1  sticky watchdog error

Behaviour:
- Reset: state=REQ_START; pc_halt=1, imem_req=0, imem_addr=0, instr=0, instr_valid=0, fetch_err=0, watchdog=0, discard=0. Reset mid-transaction abandons it. An ack arriving outside REQ is ignored.
- States: REQ_START, REQ, VALID, ADVANCE, ERR. pc_halt=0 only in ADVANCE.
- REQ_START: imem_addr<=pc, imem_req<=1, watchdog<=0; go to REQ.
- REQ: imem_req=1, watchdog increments each cycle.
  - On imem_ack with discard=0: instr<=imem_rdata, instr_valid<=1, imem_req<=0; go to VALID.
  - On imem_ack with discard=1: imem_req<=0, discard<=0; go to ADVANCE.
  - flush while in REQ sets discard. The bus request is never withdrawn early.
  - flush and ack in the same cycle: data is discarded; go to ADVANCE.
  - No ack and watchdog==TIMEOUT-1: imem_req<=0, fetch_err<=1; go to ERR.
  - ack in the same cycle as the timeout: ack wins.
- VALID: instr_valid=1, instr held stable.
  - instr_ready=1: instr_valid<=0; go to ADVANCE.
  - flush=1: instr_valid<=0; go to ADVANCE. flush with instr_ready in the same cycle means flush wins and the instruction is not accepted.
- ADVANCE: pc_halt=0 for exactly one cycle so the PC loads its next/branch value; go to REQ_START.
- Minimum fetch period is 4 cycles: REQ_START, REQ with immediate ack, VALID with ready high, ADVANCE.
- ERR: imem_req=0, instr_valid=0, pc_halt=1, fetch_err=1. Terminal until reset. flush is ignored.
- flush in REQ_START or ADVANCE: no effect, because no instruction is held yet.
- Watchdog width: clog2(TIMEOUT)+1 bits. It never wraps because it clears on REQ entry.

Decomposition:
- Package fetch_pkg: state enum (REQ_START, REQ, VALID, ADVANCE, ERR) and NOP_INSTR=0 constant.
- One sub-module, fetch_watchdog: clear/enable counter with terminal-count output, parameterised by TIMEOUT.

Test Plan:
- Reset low 2 cycles then high, pc=0x0, ack on 2nd REQ cycle with rdata=0x8C010004 -> imem_addr=0x0, instr=0x8C010004, instr_valid=1, pc_halt=0 for one cycle after ready.
- instr_ready low 5 cycles in VALID -> instr held at 0x8C010004, pc_halt=1 throughout; ADVANCE follows the cycle after ready rises.
- flush during REQ, ack 3 cycles later with 0xDEADBEEF -> instr_valid never asserts, ADVANCE one cycle, next fetch address = new pc (0x40).
- flush and instr_ready together in VALID -> instruction dropped, single ADVANCE, no duplicate pc_halt low pulse.
- No ack for TIMEOUT=16 cycles -> fetch_err=1 on cycle 16, imem_req=0; a later ack is ignored; reset clears fetch_err.
- Reset asserted mid-REQ with ack in the same cycle -> all outputs return to reset values, instr_valid stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        REQ_START,
        REQ,
        VALID,
        ADVANCE,
        ERR
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// Clear/enable cycle counter; expired flags the last allowed wait cycle.
module fetch_watchdog #(
    parameter int TIMEOUT = 16,
    localparam int CW = $clog2(TIMEOUT) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Cleared on every request start, so the count never wraps.
    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer: issues the PC to instruction memory, hands the word to decode,
// and releases the PC for one cycle once the instruction is accepted or flushed.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              flush,
    output logic              fetch_err
);

    fetch_state_t state, state_next;
    logic         discard;
    logic         capture;
    logic         set_discard;
    logic         clr_discard;
    logic         wd_expired;

    fetch_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == REQ_START),
        .enable (state == REQ),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= REQ_START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        set_discard = 1'b0;
        clr_discard = 1'b0;
        case (state)
            REQ_START: state_next = REQ;
            REQ: begin
                // An ack always beats the watchdog; a flush arriving with it drops the data.
                if (imem_ack) begin
                    if (discard || flush) begin
                        clr_discard = 1'b1;
                        state_next  = ADVANCE;
                    end else begin
                        capture    = 1'b1;
                        state_next = VALID;
                    end
                end else begin
                    set_discard = flush;
                    if (wd_expired) begin
                        state_next = ERR;
                    end
                end
            end
            VALID: begin
                if (flush || instr_ready) begin
                    state_next = ADVANCE;
                end
            end
            ADVANCE: state_next = REQ_START;
            ERR:     state_next = ERR;
            default: state_next = REQ_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= DATA_W'(NOP_INSTR);
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            discard     <= 1'b0;
        end else begin
            imem_req    <= (state_next == REQ);
            instr_valid <= (state_next == VALID);
            fetch_err   <= fetch_err | (state_next == ERR);
            if (state == REQ_START) begin
                imem_addr <= pc;
            end
            if (capture) begin
                instr <= imem_rdata;
            end
            if (clr_discard) begin
                discard <= 1'b0;
            end else if (set_discard) begin
                discard <= 1'b1;
            end
        end
    end

    assign pc_halt = (state != ADVANCE);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised fetch traffic with a transaction-level scoreboard, plus directed
// reset, timeout and reset-during-request checks.
module tb_fetch_unit;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              pc_halt;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic              flush = 1'b0;
    logic              fetch_err;

    fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_halt    (pc_halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .flush      (flush),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // One record per fetch: where it must read, whether decode should ever
    // see it, whether decode should take it, and what word it carries.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              valid_exp;
        logic              deliver;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    int                compared = 0;
    int                mismatched = 0;
    logic              mon_en = 1'b0;
    logic [ADDR_W-1:0] pc_next = '0;

    logic              m_prev_req = 1'b0;
    logic              m_prev_halt = 1'b1;
    logic              m_saw_valid = 1'b0;
    logic              m_accepted = 1'b0;
    logic [ADDR_W-1:0] m_req_addr = '0;
    logic [DATA_W-1:0] m_got = '0;
    logic [DATA_W-1:0] m_held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic quiet_inputs();
        imem_ack    = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, "_pc_halt"}, pc_halt, 1'b1);
        check_bit({tag, "_imem_req"}, imem_req, 1'b0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check_bit({tag, "_instr_valid"}, instr_valid, 1'b0);
        check_bit({tag, "_fetch_err"}, fetch_err, 1'b0);
    endtask

    // ack_d: REQ cycle carrying the ack; fmode 0 = plain, 1 = flush in REQ at
    // cycle fcyc, 2 = flush in VALID at cycle fcyc; rdy_d: VALID cycle raising ready.
    task automatic do_fetch(input int ack_d, input int fmode, input int fcyc, input int rdy_d,
                            input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] npc);
        int   n;
        exp_t e;
        n = 0;
        while (!imem_req && n < 10) begin
            if (!pc_halt) pc = pc_next;
            flush       = ($urandom_range(0, 3) == 0);
            imem_ack    = ($urandom_range(0, 3) == 0);
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            fail_now("req_wait");
            quiet_inputs();
            return;
        end
        e.addr      = pc;
        e.valid_exp = (fmode != 1);
        e.deliver   = (fmode == 0);
        e.data      = data;
        exp_q.push_back(e);
        for (int c = 0; c <= ack_d; c++) begin
            imem_ack    = (c == ack_d);
            imem_rdata  = (c == ack_d) ? data : $urandom;
            flush       = (fmode == 1 && c == fcyc);
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (fmode != 1) begin
            for (int c = 0; c <= rdy_d; c++) begin
                instr_ready = (c == rdy_d);
                flush       = (fmode == 2 && c == fcyc);
                imem_ack    = ($urandom_range(0, 3) == 0);
                imem_rdata  = $urandom;
                @(negedge clk);
                if (fmode == 2 && c == fcyc) break;
            end
        end
        quiet_inputs();
        pc_next = npc;
    endtask

    // Monitor: tracks each fetch between releases of the PC and scores it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                m_prev_req  = 1'b0;
                m_prev_halt = 1'b1;
                m_saw_valid = 1'b0;
                m_accepted  = 1'b0;
                continue;
            end
            if (imem_req && !m_prev_req) m_req_addr = imem_addr;
            if (imem_req && instr_valid) fail_now("req_and_valid");
            if (instr_valid) begin
                if (m_saw_valid) check("instr_stable", instr, m_held);
                else m_held = instr;
                m_saw_valid = 1'b1;
                if (instr_ready && !flush) begin
                    m_accepted = 1'b1;
                    m_got      = instr;
                end
            end
            if (!pc_halt) begin
                if (!m_prev_halt) fail_now("advance_len");
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_advance");
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_addr", m_req_addr, e.addr);
                    check_bit("valid_seen", m_saw_valid, e.valid_exp);
                    check_bit("accepted", m_accepted, e.deliver);
                    if (e.deliver) check("instr", m_got, e.data);
                end
                m_saw_valid = 1'b0;
                m_accepted  = 1'b0;
            end
            m_prev_req  = imem_req;
            m_prev_halt = pc_halt;
        end
    end

    initial begin
        int ack_d, fmode, fcyc, rdy_d, n;
        logic [ADDR_W-1:0] npc;

        quiet_inputs();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset  = 1'b1;
        mon_en = 1'b1;

        do_fetch(1, 0, 0, 0, 32'h8C01_0004, 32'h0000_0004);
        do_fetch(0, 0, 0, 5, 32'h8C01_0004, 32'h0000_0008);
        do_fetch(3, 1, 0, 0, 32'hDEAD_BEEF, 32'h0000_0040);
        do_fetch(0, 0, 0, 0, $urandom, 32'h0000_0044);
        do_fetch(1, 2, 2, 2, $urandom, 32'h0000_0048);
        do_fetch(0, 1, 0, 0, $urandom, 32'h0000_004C);
        do_fetch(TIMEOUT - 1, 0, 0, 1, $urandom, 32'h0000_0050);

        for (int i = 0; i < 150; i++) begin
            ack_d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 3);
            rdy_d = $urandom_range(0, 4);
            fmode = $urandom_range(0, 2);
            fcyc  = (fmode == 1) ? $urandom_range(0, ack_d) : $urandom_range(0, rdy_d);
            npc   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc_next + 32'd4;
            do_fetch(ack_d, fmode, fcyc, rdy_d, $urandom, npc);
        end

        n = 0;
        #3;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        mon_en = 1'b0;

        // Memory never answers: watchdog must trap after TIMEOUT request cycles.
        quiet_inputs();
        @(negedge clk);
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) fail_now("timeout_req_wait");
        repeat (TIMEOUT - 1) @(negedge clk);
        check_bit("err_before_timeout", fetch_err, 1'b0);
        check_bit("req_before_timeout", imem_req, 1'b1);
        @(negedge clk);
        check_bit("err_at_timeout", fetch_err, 1'b1);
        check_bit("req_at_timeout", imem_req, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        flush      = 1'b1;
        @(negedge clk);
        quiet_inputs();
        repeat (3) @(negedge clk);
        check_bit("err_sticky", fetch_err, 1'b1);
        check_bit("err_valid", instr_valid, 1'b0);
        check_bit("err_req", imem_req, 1'b0);
        check_bit("err_halt", pc_halt, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_bit("err_cleared", fetch_err, 1'b0);
        reset = 1'b1;

        // Reset lands on a request cycle together with an ack.
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) fail_now("midreq_wait");
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        quiet_inputs();
        check_reset_values("midreq");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("midreq_no_valid", instr_valid, 1'b0);
        check_bit("midreq_req", imem_req, 1'b1);
        check("midreq_addr", imem_addr, pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
